// File: rtl/dram_ring_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | dram_ring_arbiter_if                                                       |
// | FIFO-side and memory-side signals of the DRAM ring arbiter.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface dram_ring_arbiter_if;
   logic        wr_valid;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        rd_enable;
   logic        rd_ready;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic [31:0] mem_addr;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic [31:0] mem_rdata;
   logic        mem_waitrequest;
   logic [31:0] level;
   logic        wr_wrap;
   logic        rd_wrap;

   // master: the arbiter itself; slave: FIFOs plus memory bus around it
   modport master (
      input  wr_valid, wr_data, rd_enable, rd_ready, mem_rdata, mem_waitrequest,
      output wr_ready, rd_valid, rd_data, mem_addr, mem_write, mem_wdata,
             mem_read, level, wr_wrap, rd_wrap
   );

   modport slave (
      output wr_valid, wr_data, rd_enable, rd_ready, mem_rdata, mem_waitrequest,
      input  wr_ready, rd_valid, rd_data, mem_addr, mem_write, mem_wdata,
             mem_read, level, wr_wrap, rd_wrap
   );
endinterface

`default_nettype wire

// File: rtl/dram_ring_arbiter.sv
// +----------------------------------------------------------------------------+
// | dram_ring_arbiter                                                          |
// | Round-robin burst arbiter sharing one DDR2 port between a ring writer and  |
// | a ring reader, with a fill level guarding overtake and lapping.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dram_ring_arbiter #(
   parameter int          FRAME_WORDS = 640,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          BURST       = 16
) (
   input  logic                ctrl_clk,
   input  logic                reset,
   dram_ring_arbiter_if.master bus
);

   localparam int PTR_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;

   localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(FRAME_WORDS - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST - 1);
   localparam logic [31:0]       LEVEL_FULL = 32'(FRAME_WORDS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [31:0]       level_q, level_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              last_rd_q, last_rd_d;

   logic              wr_elig;
   logic              rd_elig;
   logic              cmd_write;
   logic              cmd_read;
   logic              wacc;
   logic              racc;
   logic [PTR_W-1:0]  addr_ptr;

   always_comb begin
      wr_elig   = bus.wr_valid & (level_q < LEVEL_FULL);
      rd_elig   = bus.rd_enable & bus.rd_ready & (level_q != 32'd0);
      cmd_write = (state_q == WRITE) & wr_elig;
      cmd_read  = (state_q == READ) & rd_elig;
      wacc      = cmd_write & ~bus.mem_waitrequest;
      racc      = cmd_read & ~bus.mem_waitrequest;
      addr_ptr  = (state_q == WRITE) ? wr_ptr_q : rd_ptr_q;
   end

   assign bus.mem_write = cmd_write;
   assign bus.mem_read  = cmd_read;
   assign bus.wr_ready  = wacc;
   assign bus.rd_valid  = racc;
   assign bus.mem_wdata = bus.wr_data;
   assign bus.rd_data   = bus.mem_rdata;
   assign bus.mem_addr  = BASE_ADDR + (32'(addr_ptr) << 2);
   assign bus.level     = level_q;
   assign bus.wr_wrap   = wacc & (wr_ptr_q == PTR_LAST);
   assign bus.rd_wrap   = racc & (rd_ptr_q == PTR_LAST);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wacc) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
         level_d  = level_q + 32'd1;
      end else if (racc) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
         level_d  = level_q - 32'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      last_rd_d = last_rd_q;
      case (state_q)
         IDLE: begin
            beat_d = '0;
            // On a tie the writer wins only if the reader had the last grant
            if (wr_elig && (!rd_elig || last_rd_q)) begin
               state_d   = WRITE;
               last_rd_d = 1'b0;
            end else if (rd_elig) begin
               state_d   = READ;
               last_rd_d = 1'b1;
            end
         end
         WRITE: begin
            if (wacc) begin
               if (beat_q == BEAT_LAST) begin
                  state_d = IDLE;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end else if (!wr_elig && !bus.mem_waitrequest) begin
               state_d = IDLE;
               beat_d  = '0;
            end
         end
         READ: begin
            if (racc) begin
               if (beat_q == BEAT_LAST) begin
                  state_d = IDLE;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end else if (!rd_elig && !bus.mem_waitrequest) begin
               state_d = IDLE;
               beat_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            beat_d  = '0;
         end
      endcase
   end

   always_ff @(posedge ctrl_clk) begin
      if (reset) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= 32'd0;
         beat_q    <= '0;
         last_rd_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         beat_q    <= beat_d;
         last_rd_q <= last_rd_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dram_ring_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_dram_ring_arbiter                                                       |
// | Directed and random stimulus against a queue-based ring reference model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dram_ring_arbiter;

   localparam int          FW    = 14;
   localparam int          BURST = 6;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic ctrl_clk = 1'b0;
   logic reset    = 1'b1;

   dram_ring_arbiter_if bus ();

   dram_ring_arbiter #(
      .FRAME_WORDS (FW),
      .BASE_ADDR   (BASE),
      .BURST       (BURST)
   ) u_dut (
      .ctrl_clk (ctrl_clk),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 ctrl_clk = ~ctrl_clk;

   // DRAM model: word storage addressed by whatever the arbiter drives
   logic [31:0] dram [0:FW-1];
   int unsigned dram_idx;

   always_comb begin
      dram_idx      = (bus.mem_addr - BASE) >> 2;
      bus.mem_rdata = (dram_idx < FW) ? dram[dram_idx] : 32'hDEAD_BEEF;
   end

   always @(posedge ctrl_clk) begin
      if (!reset && bus.mem_write && !bus.mem_waitrequest && dram_idx < FW)
         dram[dram_idx] <= bus.mem_wdata;
   end

   int checks = 0;
   int errors = 0;

   // Reference model: owner 0 = none, 1 = writer, 2 = reader
   int          owner;
   int          beats;
   int          last_owner;
   int          wr_cnt;
   int          rd_cnt;
   logic [31:0] ring_q [$];
   logic [31:0] wdata_head;
   bit          pend_w;
   bit          pend_r;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      owner      = 0;
      beats      = 0;
      last_owner = 2;
      wr_cnt     = 0;
      rd_cnt     = 0;
      ring_q.delete();
      pend_w     = 1'b0;
      pend_r     = 1'b0;
   endtask

   task automatic cycle(input bit rst, input bit wv, input bit re, input bit rr, input bit wreq);
      bit          w_elig, r_elig, e_w, e_r, e_wacc, e_racc;
      logic [31:0] e_addr;
      if (pend_w) wv = 1'b1;
      if (pend_r) begin
         re = 1'b1;
         rr = 1'b1;
      end
      reset               = rst;
      bus.wr_valid        = wv;
      bus.wr_data         = wdata_head;
      bus.rd_enable       = re;
      bus.rd_ready        = rr;
      bus.mem_waitrequest = wreq;

      w_elig = wv && (ring_q.size() < FW);
      r_elig = re && rr && (ring_q.size() != 0);
      e_w    = (owner == 1) && w_elig;
      e_r    = (owner == 2) && r_elig;
      e_wacc = e_w && !wreq;
      e_racc = e_r && !wreq;
      e_addr = BASE + 32'(4 * (((owner == 1) ? wr_cnt : rd_cnt) % FW));

      @(negedge ctrl_clk);
      chk("mem_write", 32'(bus.mem_write), 32'(e_w));
      chk("mem_read", 32'(bus.mem_read), 32'(e_r));
      chk("wr_ready", 32'(bus.wr_ready), 32'(e_wacc));
      chk("rd_valid", 32'(bus.rd_valid), 32'(e_racc));
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("level", bus.level, 32'(ring_q.size()));
      chk("wr_wrap", 32'(bus.wr_wrap), 32'(e_wacc && (wr_cnt % FW == FW - 1)));
      chk("rd_wrap", 32'(bus.rd_wrap), 32'(e_racc && (rd_cnt % FW == FW - 1)));
      if (e_w) chk("mem_wdata", bus.mem_wdata, wdata_head);
      if (e_racc) chk("rd_data", bus.rd_data, ring_q[0]);

      if (rst) begin
         model_reset();
      end else begin
         pend_w = e_w && wreq;
         pend_r = e_r && wreq;
         if (owner == 0) begin
            if (w_elig && r_elig) owner = (last_owner == 1) ? 2 : 1;
            else if (w_elig)      owner = 1;
            else if (r_elig)      owner = 2;
            if (owner != 0) begin
               last_owner = owner;
               beats      = 0;
            end
         end else if (e_wacc || e_racc) begin
            if (e_wacc) begin
               ring_q.push_back(wdata_head);
               wr_cnt++;
            end else begin
               void'(ring_q.pop_front());
               rd_cnt++;
            end
            beats++;
            if (beats == BURST) owner = 0;
         end else if (!wreq && ((owner == 1) ? !w_elig : !r_elig)) begin
            owner = 0;
         end
      end
      if (e_wacc) wdata_head = $urandom;

      @(posedge ctrl_clk);
      #1;
   endtask

   initial begin
      bit got_reset;
      model_reset();
      wdata_head          = $urandom;
      bus.wr_valid        = 1'b0;
      bus.wr_data         = wdata_head;
      bus.rd_enable       = 1'b0;
      bus.rd_ready        = 1'b0;
      bus.mem_waitrequest = 1'b0;
      @(posedge ctrl_clk);
      #1;

      // Reset, then a quiet cycle
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);

      // Empty ring with reader enabled: no reads
      for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1, 0);

      // Write-only stream until full, through burst gaps
      for (int i = 0; i < 3 * FW; i++) cycle(0, 1, 0, 0, 0);

      // Drain to empty
      for (int i = 0; i < 3 * FW; i++) cycle(0, 0, 1, 1, 0);

      // Fairness with both sides eligible
      for (int i = 0; i < 8 * BURST; i++) cycle(0, 1, 1, 1, 0);

      // Waitrequest hold on write beat 2
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);

      // Read ready dropped mid-burst
      for (int i = 0; i < 2 * FW; i++) cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
      for (int i = 0; i < 3 * FW; i++) cycle(0, 0, 1, 1, 0);

      // Randomised traffic with changing bias
      for (int seg = 0; seg < 6; seg++) begin
         int unsigned wp, rp;
         wp = (seg % 2 == 0) ? 9 : 4;
         rp = (seg % 2 == 0) ? 4 : 9;
         for (int i = 0; i < 400; i++)
            cycle(0, $urandom_range(0, 9) < wp, $urandom_range(0, 9) < rp,
                  $urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0);
      end

      // Reset during read beat 5, then both sides eligible
      for (int i = 0; i < 3 * FW; i++) cycle(0, 1, 0, 0, 0);
      got_reset = 1'b0;
      for (int i = 0; i < 4 * BURST && !got_reset; i++) begin
         if (owner == 2 && beats == 5) begin
            cycle(1, 0, 1, 1, 0);
            got_reset = 1'b1;
         end else begin
            cycle(0, 0, 1, 1, 0);
         end
      end
      chk("reset_mid_read_reached", 32'(got_reset), 32'd1);
      for (int i = 0; i < 4 * BURST; i++) cycle(0, 1, 1, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
